// File: rtl/dmem_arbiter.sv
// Single-port data-memory sequencer: arbitrates the CPU MEM-stage port and the EXT loader/debug
// port, running each access through grant -> access -> acknowledge with a fixed access time.
module dmem_arbiter #(
    parameter int ACCESS_CYCLES = 1,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int BW = $clog2(MAX_CPU_BURST + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_CPU_BURST);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [BW-1:0] BURST_ZERO = BW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            grant_s;
    logic            grant_ext_s;
    logic            last_s;
    logic [BW-1:0]   burst_s;
    logic [BW-1:0]   burst_cnt_r;
    logic [CW-1:0]   cnt_r;
    logic            owner_r;      // 1 = EXT owns the current access
    logic            we_r;
    logic [31:0]     addr_r;
    logic [31:0]     wdata_r;
    logic            cpu_ack_r;
    logic            ext_ack_r;
    logic [31:0]     cpu_rdata_r;
    logic [31:0]     ext_rdata_r;

    assign last_s = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO);

    // Arbitration in IDLE and next-state selection
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_ext_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req && ext_req) begin
                    grant_s     = 1'b1;
                    grant_ext_s = (burst_cnt_r == BURST_MAX);
                end else if (cpu_req) begin
                    grant_s     = 1'b1;
                end else if (ext_req) begin
                    grant_s     = 1'b1;
                    grant_ext_s = 1'b1;
                end else begin
                    grant_s     = 1'b0;
                end
                if (grant_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // CPU burst counter: counts contended CPU grants so EXT cannot starve
    always_comb begin
        burst_s = burst_cnt_r;
        if (grant_s && !grant_ext_s && ext_req) begin
            if (burst_cnt_r == BURST_MAX) begin
                burst_s = burst_cnt_r;
            end else begin
                burst_s = burst_cnt_r + BURST_ONE;
            end
        end else if (grant_s) begin
            burst_s = BURST_ZERO;
        end else begin
            burst_s = burst_cnt_r;
        end
    end

    // State, operand latches, access counter, acks and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= BURST_ZERO;
            cnt_r       <= CNT_ZERO;
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            cpu_ack_r   <= 1'b0;
            ext_ack_r   <= 1'b0;
            cpu_rdata_r <= 32'd0;
            ext_rdata_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            burst_cnt_r <= burst_s;
            cpu_ack_r   <= last_s & ~owner_r;
            ext_ack_r   <= last_s & owner_r;
            if (grant_s) begin
                owner_r <= grant_ext_s;
                we_r    <= grant_ext_s ? ext_we    : cpu_we;
                addr_r  <= grant_ext_s ? ext_addr  : cpu_addr;
                wdata_r <= grant_ext_s ? ext_wdata : cpu_wdata;
                cnt_r   <= CNT_LOAD;
            end else if ((state_r == ST_BUSY) && !last_s) begin
                cnt_r   <= cnt_r - CNT_ONE;
            end
            if (last_s && !we_r && !owner_r) begin
                cpu_rdata_r <= mem_rdata;
            end
            if (last_s && !we_r && owner_r) begin
                ext_rdata_r <= mem_rdata;
            end
        end
    end

    // Strobes are gated with reset so an abandoned access never writes memory
    assign mem_read  = (state_r == ST_BUSY) & ~we_r & ~reset;
    assign mem_write = last_s & we_r & ~reset;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign ext_ack   = ext_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign ext_rdata = ext_rdata_r;
    assign cpu_stall = cpu_req & ~cpu_ack_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (ACCESS_CYCLES 1 and 3) share stimulus and are checked
// against a transaction-timeline reference model plus directed timing expectations.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

    logic [1:0]  cpu_ack_o, cpu_stall_o, ext_ack_o, mem_read_o, mem_write_o;
    logic [31:0] cpu_rdata_o [2];
    logic [31:0] ext_rdata_o [2];
    logic [31:0] mem_addr_o  [2];
    logic [31:0] mem_wdata_o [2];
    logic [31:0] mem_rdata_i [2];
    logic [31:0] env_mem     [2][256];

    assign mem_rdata_i[0] = env_mem[0][mem_addr_o[0][9:2]];
    assign mem_rdata_i[1] = env_mem[1][mem_addr_o[1][9:2]];

    dmem_arbiter #(.ACCESS_CYCLES(1), .MAX_CPU_BURST(4)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_o[0]), .cpu_rdata(cpu_rdata_o[0]), .cpu_stall(cpu_stall_o[0]),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack_o[0]), .ext_rdata(ext_rdata_o[0]),
        .mem_read(mem_read_o[0]), .mem_write(mem_write_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0])
    );

    dmem_arbiter #(.ACCESS_CYCLES(3), .MAX_CPU_BURST(4)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_o[1]), .cpu_rdata(cpu_rdata_o[1]), .cpu_stall(cpu_stall_o[1]),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack_o[1]), .ext_rdata(ext_rdata_o[1]),
        .mem_read(mem_read_o[1]), .mem_write(mem_write_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding transaction per instance, tracked by its age since grant
    bit          m_active [2];
    int          m_age    [2];
    bit          m_owner  [2];
    bit          m_we     [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_rdata  [2][2];
    int          m_burst  [2];
    logic [31:0] m_mem    [2][256];
    bit          log_en = 1'b0;
    int          log0 [$];
    int          log1 [$];

    function automatic int acc(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit e_busy(int k);
        return m_active[k] && (m_age[k] <= acc(k));
    endfunction

    function automatic bit e_ack(int k, bit who);
        return m_active[k] && (m_age[k] == acc(k) + 1) && (m_owner[k] == who);
    endfunction

    task automatic check_model(int k);
        string p;
        logic [31:0] burst_obs;
        p = $sformatf("a%0d", acc(k));
        burst_obs = (k == 0) ? 32'(dut0.burst_cnt_r) : 32'(dut1.burst_cnt_r);
        chk({p, " cpu_ack"},   32'(cpu_ack_o[k]),   32'(e_ack(k, 1'b0)));
        chk({p, " ext_ack"},   32'(ext_ack_o[k]),   32'(e_ack(k, 1'b1)));
        chk({p, " mem_read"},  32'(mem_read_o[k]),  32'(e_busy(k) && !m_we[k] && !reset));
        chk({p, " mem_write"}, 32'(mem_write_o[k]),
            32'(e_busy(k) && m_we[k] && (m_age[k] == acc(k)) && !reset));
        chk({p, " mem_addr"},  mem_addr_o[k],  m_addr[k]);
        chk({p, " mem_wdata"}, mem_wdata_o[k], m_wdata[k]);
        chk({p, " cpu_rdata"}, cpu_rdata_o[k], m_rdata[k][0]);
        chk({p, " ext_rdata"}, ext_rdata_o[k], m_rdata[k][1]);
        chk({p, " cpu_stall"}, 32'(cpu_stall_o[k]), 32'(cpu_req && !e_ack(k, 1'b0)));
        chk({p, " ack_overlap"}, 32'(cpu_ack_o[k] & ext_ack_o[k]), 32'd0);
        chk({p, " burst_cnt"}, burst_obs, 32'(m_burst[k]));
        if (log_en && (cpu_ack_o[k] || ext_ack_o[k])) begin
            if (k == 0) log0.push_back(int'(ext_ack_o[k]));
            else        log1.push_back(int'(ext_ack_o[k]));
        end
    endtask

    task automatic model_edge(int k);
        bit ge;
        if (reset) begin
            m_active[k] = 1'b0; m_age[k] = 0; m_owner[k] = 1'b0; m_we[k] = 1'b0;
            m_addr[k] = 32'd0; m_wdata[k] = 32'd0; m_burst[k] = 0;
            m_rdata[k][0] = 32'd0; m_rdata[k][1] = 32'd0;
        end else if (!m_active[k]) begin
            if (cpu_req || ext_req) begin
                ge = ext_req && (!cpu_req || (m_burst[k] == 4));
                m_active[k] = 1'b1; m_age[k] = 1; m_owner[k] = ge;
                m_we[k]    = ge ? ext_we    : cpu_we;
                m_addr[k]  = ge ? ext_addr  : cpu_addr;
                m_wdata[k] = ge ? ext_wdata : cpu_wdata;
                if (!ge && ext_req) m_burst[k] = (m_burst[k] >= 4) ? 4 : m_burst[k] + 1;
                else                m_burst[k] = 0;
            end
        end else if (m_age[k] == acc(k) + 1) begin
            m_active[k] = 1'b0;
        end else begin
            if (m_age[k] == acc(k)) begin
                if (m_we[k]) m_mem[k][m_addr[k][9:2]] = m_wdata[k];
                else         m_rdata[k][m_owner[k]] = m_mem[k][m_addr[k][9:2]];
            end
            m_age[k]++;
        end
    endtask

    // One clock cycle: check current outputs, advance the model, then let memory take its write
    task automatic step();
        bit          wr [2];
        logic [31:0] wa [2];
        logic [31:0] wd [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            check_model(k);
            wr[k] = mem_write_o[k]; wa[k] = mem_addr_o[k]; wd[k] = mem_wdata_o[k];
        end
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (wr[k]) env_mem[k][wa[k][9:2]] = wd[k];
    endtask

    task automatic preset(logic [31:0] addr, logic [31:0] val);
        for (int k = 0; k < 2; k++) begin
            env_mem[k][addr[9:2]] = val;
            m_mem[k][addr[9:2]]   = val;
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'd0; ext_wdata = 32'd0;
    endtask

    // Directed single access with spec-timing expectations; request is held for cycles < drop_at
    task automatic txn(bit ext, bit we, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] rexp, int drop_at);
        bit held, busy, ackc;
        string t;
        for (int c = 0; c <= 4; c++) begin
            held = (c < drop_at);
            idle_inputs();
            if (ext) begin
                ext_req = held; ext_we = we; ext_addr = addr; ext_wdata = wdata;
            end else begin
                cpu_req = held; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (c <= acc(k) + 1) begin
                    busy = (c >= 1) && (c <= acc(k));
                    ackc = (c == acc(k) + 1);
                    t = $sformatf("dir a%0d c%0d", acc(k), c);
                    chk({t, " mem_read"},  32'(mem_read_o[k]),  32'(busy && !we));
                    chk({t, " mem_write"}, 32'(mem_write_o[k]), 32'(busy && we && (c == acc(k))));
                    chk({t, " cpu_ack"},   32'(cpu_ack_o[k]),   32'(ackc && !ext));
                    chk({t, " ext_ack"},   32'(ext_ack_o[k]),   32'(ackc && ext));
                    chk({t, " cpu_stall"}, 32'(cpu_stall_o[k]), 32'(!ext && held && !ackc));
                    if (busy) chk({t, " mem_addr"}, mem_addr_o[k], addr);
                    if (ackc && !we) chk({t, " rdata"}, ext ? ext_rdata_o[k] : cpu_rdata_o[k], rexp);
                end
            end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    function automatic logic [31:0] raddr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    initial begin
        logic [31:0] v;
        int budget;
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            for (int k = 0; k < 2; k++) begin
                env_mem[k][i] = v;
                m_mem[k][i]   = v;
            end
        end
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;

        // Reset state
        step();
        step();
        reset = 1'b0;
        step();

        // CPU read, EXT write then CPU read, ACCESS_CYCLES=3 write, EXT dropped after grant
        preset(32'h0000_0010, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3);
        txn(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'd0, 3);
        txn(1'b0, 1'b0, 32'h0000_0020, 32'd0, 32'h1234_5678, 3);
        txn(1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 32'd0, 3);
        preset(32'h0000_0044, 32'hA5A5_A5A5);
        txn(1'b1, 1'b0, 32'h0000_0044, 32'd0, 32'hA5A5_A5A5, 1);

        // Reset on the final BUSY cycle of a CPU write
        preset(32'h0000_0040, 32'h1111_2222);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'hCAFE_F00D;
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst gate mem_write", 32'(mem_write_o[0]), 32'd0);
        step();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst a%0d keep mem", acc(k)), env_mem[k][16], 32'h1111_2222);
            chk($sformatf("rst a%0d cpu_ack", acc(k)), 32'(cpu_ack_o[k]), 32'd0);
            chk($sformatf("rst a%0d cpu_rdata", acc(k)), cpu_rdata_o[k], 32'd0);
            chk($sformatf("rst a%0d mem_addr", acc(k)), mem_addr_o[k], 32'd0);
            chk($sformatf("rst a%0d mem_rw", acc(k)), 32'({mem_read_o[k], mem_write_o[k]}), 32'd0);
        end
        chk("rst state idle", 32'(dut0.state_r), 32'd0);
        step();

        // Continuous contention: grant order must be C,C,C,C,E repeating
        reset = 1'b1;
        step();
        reset = 1'b0;
        cpu_req = 1'b1; ext_req = 1'b1;
        log_en = 1'b1;
        budget = 0;
        while (log0.size() < 20 && budget < 200) begin
            cpu_we = 1'($urandom); ext_we = 1'($urandom);
            cpu_addr = raddr(); ext_addr = raddr();
            cpu_wdata = $urandom; ext_wdata = $urandom;
            step();
            budget++;
        end
        log_en = 1'b0;
        chk("contention a1 acks", 32'(log0.size() >= 20), 32'd1);
        chk("contention a3 acks", 32'(log1.size() >= 10), 32'd1);
        for (int i = 0; i < 20 && i < log0.size(); i++)
            chk($sformatf("a1 grant %0d", i), 32'(log0[i]), 32'((i % 5) == 4));
        for (int i = 0; i < 10 && i < log1.size(); i++)
            chk($sformatf("a3 grant %0d", i), 32'(log1[i]), 32'((i % 5) == 4));
        idle_inputs();
        step();
        step();
        step();
        step();

        // Randomised traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            ext_req   = ($urandom_range(0, 2) == 0);
            cpu_we    = 1'($urandom);
            ext_we    = 1'($urandom);
            cpu_addr  = raddr();
            ext_addr  = raddr();
            cpu_wdata = $urandom;
            ext_wdata = $urandom;
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
